// File: rtl/cache_controller_pkg.sv
// Shared definitions for the two-way set-associative write-through cache.
// Holds default geometry, the data width, address field offsets and the FSM encoding.
package cache_controller_pkg;

   localparam int unsigned DEF_SETS    = 64;
   localparam int unsigned DEF_INDEX_W = 6;
   localparam int unsigned DEF_TAG_W   = 10;
   localparam int unsigned DATA_W      = 32;

   // Byte offset bits below the index field.
   localparam int unsigned INDEX_LSB = 2;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StRdMiss = 2'd1,
      StWr     = 2'd2
   } state_t;

endpackage

// File: rtl/cache_array.sv
// Per-set storage for both ways: valid, tag, data and a one-bit LRU pointer.
// Combinational lookup on the presented index/tag, synchronous single-way update.
module cache_array
   import cache_controller_pkg::*;
#(
   parameter int unsigned SETS    = DEF_SETS,
   parameter int unsigned INDEX_W = DEF_INDEX_W,
   parameter int unsigned TAG_W   = DEF_TAG_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [INDEX_W-1:0] index,
   input  logic [TAG_W-1:0]   tag,
   output logic               hit0,
   output logic               hit1,
   output logic [DATA_W-1:0]  data0,
   output logic [DATA_W-1:0]  data1,
   output logic               lru,
   output logic               valid0,
   output logic               valid1,
   input  logic               we,
   input  logic               way,
   input  logic [TAG_W-1:0]   wr_tag,
   input  logic [DATA_W-1:0]  wr_data,
   input  logic               lru_we,
   input  logic               lru_val
);

   logic [SETS-1:0]   valid0_q;
   logic [SETS-1:0]   valid1_q;
   logic [SETS-1:0]   lru_q;
   logic [TAG_W-1:0]  tag0_q  [SETS];
   logic [TAG_W-1:0]  tag1_q  [SETS];
   logic [DATA_W-1:0] data0_q [SETS];
   logic [DATA_W-1:0] data1_q [SETS];

   always_comb begin
      valid0 = valid0_q[index];
      valid1 = valid1_q[index];
      lru    = lru_q[index];
      data0  = data0_q[index];
      data1  = data1_q[index];
      hit0   = valid0 && (tag0_q[index] == tag);
      hit1   = valid1 && (tag1_q[index] == tag);
   end

   // Only the control bits are reset; stale tag/data are masked by valid.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid0_q <= '0;
         valid1_q <= '0;
         lru_q    <= '0;
      end else begin
         if (we && !way) valid0_q[index] <= 1'b1;
         if (we && way)  valid1_q[index] <= 1'b1;
         if (lru_we)     lru_q[index]    <= lru_val;
      end
   end

   always_ff @(posedge clk) begin
      if (we) begin
         if (!way) begin
            tag0_q[index]  <= wr_tag;
            data0_q[index] <= wr_data;
         end else begin
            tag1_q[index]  <= wr_tag;
            data1_q[index] <= wr_data;
         end
      end
   end

endmodule

// File: rtl/cache_controller.sv
// Two-way write-through, no-write-allocate cache between the MEM stage and the SRAM controller.
// Read hits complete in the request cycle; misses and all writes go through the SRAM handshake.
module cache_controller
   import cache_controller_pkg::*;
#(
   parameter int unsigned SETS    = DEF_SETS,
   parameter int unsigned INDEX_W = DEF_INDEX_W,
   parameter int unsigned TAG_W   = DEF_TAG_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       address,
   input  logic [DATA_W-1:0] wdata,
   input  logic              MEM_R_EN,
   input  logic              MEM_W_EN,
   output logic [DATA_W-1:0] rdata,
   output logic              ready,
   output logic [31:0]       sram_address,
   output logic [DATA_W-1:0] sram_wdata,
   output logic              sram_read_en,
   output logic              sram_write_en,
   input  logic [DATA_W-1:0] sram_rdata,
   input  logic              sram_ready
);

   localparam int unsigned TAG_LSB = INDEX_LSB + INDEX_W;

   state_t state_q, state_d;

   logic [INDEX_W-1:0] index;
   logic [TAG_W-1:0]   tag;
   logic               hit0, hit1, hit;
   logic [DATA_W-1:0]  data0, data1, hit_data;
   logic               lru, valid0, valid1, victim;
   logic               arr_we, arr_way, lru_we, lru_val;
   logic [DATA_W-1:0]  arr_data;

   assign index    = address[TAG_LSB-1:INDEX_LSB];
   assign tag      = address[TAG_LSB+TAG_W-1:TAG_LSB];
   assign hit      = hit0 || hit1;
   assign hit_data = hit1 ? data1 : data0;
   // Prefer an empty way (way0 first); otherwise replace the LRU way.
   assign victim   = !valid0 ? 1'b0 : (!valid1 ? 1'b1 : lru);

   cache_array #(
      .SETS    (SETS),
      .INDEX_W (INDEX_W),
      .TAG_W   (TAG_W)
   ) u_array (
      .clk     (clk),
      .rst     (rst),
      .index   (index),
      .tag     (tag),
      .hit0    (hit0),
      .hit1    (hit1),
      .data0   (data0),
      .data1   (data1),
      .lru     (lru),
      .valid0  (valid0),
      .valid1  (valid1),
      .we      (arr_we),
      .way     (arr_way),
      .wr_tag  (tag),
      .wr_data (arr_data),
      .lru_we  (lru_we),
      .lru_val (lru_val)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= StIdle;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d       = state_q;
      ready         = 1'b0;
      rdata         = '0;
      sram_address  = '0;
      sram_wdata    = '0;
      sram_read_en  = 1'b0;
      sram_write_en = 1'b0;
      arr_we        = 1'b0;
      arr_way       = 1'b0;
      arr_data      = sram_rdata;
      lru_we        = 1'b0;
      lru_val       = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (MEM_W_EN) begin
               state_d = StWr;
            end else if (MEM_R_EN) begin
               if (hit) begin
                  ready   = 1'b1;
                  rdata   = hit_data;
                  lru_we  = 1'b1;
                  lru_val = ~hit1;
               end else begin
                  state_d = StRdMiss;
               end
            end else begin
               ready = 1'b1;
            end
         end

         StRdMiss: begin
            sram_read_en = 1'b1;
            sram_address = address;
            if (sram_ready) begin
               ready   = 1'b1;
               rdata   = sram_rdata;
               arr_we  = 1'b1;
               arr_way = victim;
               lru_we  = 1'b1;
               lru_val = ~victim;
               state_d = StIdle;
            end
         end

         StWr: begin
            sram_write_en = 1'b1;
            sram_wdata    = wdata;
            sram_address  = address;
            if (sram_ready) begin
               ready = 1'b1;
               // Write-through with no allocation: only refresh a line already present.
               if (hit) begin
                  arr_we   = 1'b1;
                  arr_way  = hit1;
                  arr_data = wdata;
                  lru_we   = 1'b1;
                  lru_val  = ~hit1;
               end
               state_d = StIdle;
            end
         end

         default: state_d = StIdle;
      endcase
   end

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller: transaction-level cache model, SRAM controller model
// with a seven-cycle request, and one negedge compare process for all outputs.
module tb_cache_controller;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] address = '0;
   logic [31:0] wdata = '0;
   logic        MEM_R_EN = 1'b0;
   logic        MEM_W_EN = 1'b0;
   logic [31:0] rdata;
   logic        ready;
   logic [31:0] sram_address;
   logic [31:0] sram_wdata;
   logic        sram_read_en;
   logic        sram_write_en;
   logic [31:0] sram_rdata;
   logic        sram_ready;

   always #5 clk = ~clk;

   cache_controller dut (
      .clk           (clk),
      .rst           (rst),
      .address       (address),
      .wdata         (wdata),
      .MEM_R_EN      (MEM_R_EN),
      .MEM_W_EN      (MEM_W_EN),
      .rdata         (rdata),
      .ready         (ready),
      .sram_address  (sram_address),
      .sram_wdata    (sram_wdata),
      .sram_read_en  (sram_read_en),
      .sram_write_en (sram_write_en),
      .sram_rdata    (sram_rdata),
      .sram_ready    (sram_ready)
   );

   // SRAM controller model: ready on the seventh cycle a request is held.
   bit          mem_v [1024];
   logic [31:0] mem_d [1024];
   int          sram_cnt;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (mem_v[a[11:2]]) return mem_d[a[11:2]];
      if (a == 32'h0000_0400) return 32'hDEAD_BEEF;
      return {a[15:0], 16'hA5A5};
   endfunction

   assign sram_ready = (sram_read_en || sram_write_en) && (sram_cnt == 6);
   assign sram_rdata = mem_word(sram_address);

   always @(posedge clk or negedge rst) begin
      if (!rst) sram_cnt <= 0;
      else if (sram_ready) sram_cnt <= 0;
      else if (sram_read_en || sram_write_en) sram_cnt <= sram_cnt + 1;
   end

   always @(posedge clk) begin
      if (sram_write_en && sram_ready) begin
         mem_v[sram_address[11:2]] <= 1'b1;
         mem_d[sram_address[11:2]] <= sram_wdata;
      end
   end

   // Cache model: per set, two ways plus an LRU pointer.
   bit          m_valid [64][2];
   logic [9:0]  m_tag   [64][2];
   logic [31:0] m_data  [64][2];
   bit          m_lru   [64];

   // Expected outputs for the current cycle, plus literal pins on the model.
   logic        exp_ready, exp_rd_en, exp_wr_en;
   logic [31:0] exp_rdata, exp_addr, exp_wdata;
   bit          chk_on = 1'b0;
   bit          lit_hit_chk = 1'b0, lit_hit_act, lit_hit_exp;
   bit          lit_dat_chk = 1'b0;
   logic [31:0] lit_dat_act, lit_dat_exp;
   int          vectors = 0;
   int          miscompares = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %h, want %h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         check("ready", {31'd0, ready}, {31'd0, exp_ready});
         check("rdata", rdata, exp_rdata);
         check("sram_read_en", {31'd0, sram_read_en}, {31'd0, exp_rd_en});
         check("sram_write_en", {31'd0, sram_write_en}, {31'd0, exp_wr_en});
         check("sram_address", sram_address, exp_addr);
         check("sram_wdata", sram_wdata, exp_wdata);
         if (lit_hit_chk) check("model_hit", {31'd0, lit_hit_act}, {31'd0, lit_hit_exp});
         if (lit_dat_chk) check("model_rdata", lit_dat_act, lit_dat_exp);
      end
   end

   task automatic set_exp(input logic r, input logic [31:0] rd, input logic re, input logic we,
                          input logic [31:0] a, input logic [31:0] wd);
      exp_ready = r;
      exp_rdata = rd;
      exp_rd_en = re;
      exp_wr_en = we;
      exp_addr  = a;
      exp_wdata = wd;
   endtask

   task automatic next_cycle();
      @(negedge clk);
      @(posedge clk);
      #1;
      lit_hit_chk = 1'b0;
      lit_dat_chk = 1'b0;
   endtask

   task automatic idle_cycle();
      MEM_R_EN = 1'b0;
      MEM_W_EN = 1'b0;
      set_exp(1'b1, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
      next_cycle();
   endtask

   // One request, held until completion. rst_at >= 0 pulls reset in that cycle of a miss/write.
   task automatic run_req(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                          input bit lit_hit, input bit chk_dat, input logic [31:0] lit_dat,
                          input int rst_at);
      int          s;
      int          hw;
      int          v;
      logic [9:0]  t;
      logic [31:0] rd_val;
      s  = int'(a[7:2]);
      t  = a[17:8];
      hw = -1;
      for (int w = 0; w < 2; w++)
         if (m_valid[s][w] && m_tag[s][w] == t) hw = w;
      MEM_R_EN    = rd;
      MEM_W_EN    = wr;
      address     = a;
      wdata       = d;
      lit_hit_chk = 1'b1;
      lit_hit_act = (hw >= 0);
      lit_hit_exp = lit_hit;
      if (!wr && hw >= 0) begin
         set_exp(1'b1, m_data[s][hw], 1'b0, 1'b0, 32'd0, 32'd0);
         lit_dat_chk = chk_dat;
         lit_dat_act = m_data[s][hw];
         lit_dat_exp = lit_dat;
         next_cycle();
         m_lru[s] = (hw == 0);
         return;
      end
      for (int k = 0; k < 8; k++) begin
         if (k == rst_at) begin
            rst      = 1'b0;
            MEM_R_EN = 1'b0;
            MEM_W_EN = 1'b0;
            set_exp(1'b1, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
            next_cycle();
            rst = 1'b1;
            for (int i = 0; i < 64; i++) begin
               m_valid[i][0] = 1'b0;
               m_valid[i][1] = 1'b0;
               m_lru[i]      = 1'b0;
            end
            return;
         end
         rd_val = (k == 7 && !wr) ? mem_word(a) : 32'd0;
         set_exp(k == 7, rd_val, (k >= 1) && !wr, (k >= 1) && wr,
                 (k >= 1) ? a : 32'd0, ((k >= 1) && wr) ? d : 32'd0);
         if (k == 7) begin
            lit_dat_chk = chk_dat;
            lit_dat_act = rd_val;
            lit_dat_exp = lit_dat;
         end
         next_cycle();
      end
      if (wr) begin
         if (hw >= 0) begin
            m_data[s][hw] = d;
            m_lru[s]      = (hw == 0);
         end
      end else begin
         v = !m_valid[s][0] ? 0 : (!m_valid[s][1] ? 1 : int'(m_lru[s]));
         m_valid[s][v] = 1'b1;
         m_tag[s][v]   = t;
         m_data[s][v]  = mem_word(a);
         m_lru[s]      = (v == 0);
      end
   endtask

   initial begin
      set_exp(1'b1, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
      #2 rst = 1'b0;
      chk_on = 1'b1;
      @(posedge clk);
      #1 rst = 1'b1;
      idle_cycle();

      // Cold miss then immediate hit.
      run_req(1, 0, 32'h400, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF, -1);
      run_req(1, 0, 32'h400, 32'h0, 1'b1, 1'b1, 32'hDEAD_BEEF, -1);
      idle_cycle();

      // Fill both ways of set 0, then LRU eviction of 0x500 by 0x600.
      run_req(1, 0, 32'h500, 32'h0, 1'b0, 1'b1, 32'h0500_A5A5, -1);
      run_req(1, 0, 32'h400, 32'h0, 1'b1, 1'b0, 32'h0, -1);
      run_req(1, 0, 32'h600, 32'h0, 1'b0, 1'b1, 32'h0600_A5A5, -1);
      run_req(1, 0, 32'h400, 32'h0, 1'b1, 1'b0, 32'h0, -1);
      run_req(1, 0, 32'h500, 32'h0, 1'b0, 1'b0, 32'h0, -1);

      // Write hit updates the line; write miss does not allocate.
      run_req(0, 1, 32'h400, 32'h1234_5678, 1'b1, 1'b0, 32'h0, -1);
      run_req(1, 0, 32'h400, 32'h0, 1'b1, 1'b1, 32'h1234_5678, -1);
      run_req(0, 1, 32'h800, 32'h5555_AAAA, 1'b0, 1'b0, 32'h0, -1);
      run_req(1, 0, 32'h800, 32'h0, 1'b0, 1'b1, 32'h5555_AAAA, -1);
      idle_cycle();

      // Both enables high: write takes priority.
      run_req(1, 1, 32'h400, 32'hCAFE_F00D, 1'b1, 1'b0, 32'h0, -1);
      run_req(1, 0, 32'h400, 32'h0, 1'b1, 1'b1, 32'hCAFE_F00D, -1);

      // Reset in cycle 4 of a miss, then the previously cached line misses.
      run_req(1, 0, 32'h900, 32'h0, 1'b0, 1'b0, 32'h0, 4);
      idle_cycle();
      run_req(1, 0, 32'h400, 32'h0, 1'b0, 1'b1, 32'hCAFE_F00D, -1);
      run_req(1, 0, 32'h400, 32'h0, 1'b1, 1'b1, 32'hCAFE_F00D, -1);
      idle_cycle();

      chk_on = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
